// File: rtl/bcp_pkg.sv
// Shared types for the BCP trail FIFO: one trail entry is a literal, its decision level
// and whether it was a decision or an implication.
package bcp_pkg;

    localparam int unsigned LIT_W = 16;
    localparam int unsigned DL_W  = 8;

    typedef struct packed {
        logic [LIT_W-1:0] lit;
        logic [DL_W-1:0]  dl;
        logic             is_dec;
    } trail_entry_t;

endpackage

// File: rtl/gray_ptr_counter.sv
// Binary pointer with a registered Gray-coded copy; both update on the same edge.
module gray_ptr_counter #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] bin,
    output logic [W-1:0] gray
);

    logic [W-1:0] bin_q, bin_d;
    logic [W-1:0] gray_q, gray_d;

    always_comb begin
        bin_d = bin_q;
        if (clr) begin
            bin_d = '0;
        end else if (inc) begin
            bin_d = bin_q + W'(1);
        end
        // Gray is derived from the next binary value so it is a clean flop output.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;

endmodule

// File: rtl/bcp_trail_fifo.sv
// Trail FIFO between the BCP implication engine and the conflict analyzer, with
// first-word fall-through head and Gray-coded pointer exports.
module bcp_trail_fifo
    import bcp_pkg::*;
#(
    parameter int unsigned LIT_W  = bcp_pkg::LIT_W,
    parameter int unsigned DL_W   = bcp_pkg::DL_W,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [LIT_W-1:0]  push_lit,
    input  logic [DL_W-1:0]   push_dl,
    input  logic              push_is_dec,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [LIT_W-1:0]  pop_lit,
    output logic [DL_W-1:0]   pop_dl,
    output logic              pop_is_dec,
    output logic [ADDR_W:0]   wr_ptr_gray,
    output logic [ADDR_W:0]   rd_ptr_gray,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned PW    = ADDR_W + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [PW-1:0] wr_bin, rd_bin;
    logic [PW-1:0] count_q, count_d;
    logic          full, empty;
    logic          wr_inc, rd_inc;
    trail_entry_t  push_entry, head_entry;
    trail_entry_t  mem_q [DEPTH];

    assign empty = (wr_ptr_gray == rd_ptr_gray);
    assign full  = (wr_ptr_gray[PW-1:PW-2] == ~rd_ptr_gray[PW-1:PW-2]) &&
                   (wr_ptr_gray[PW-3:0] == rd_ptr_gray[PW-3:0]);

    assign push_ready = !full;
    assign pop_valid  = !empty;

    // A flush wins over any handshake in the same cycle.
    assign wr_inc = push_valid && push_ready && !flush;
    assign rd_inc = pop_valid && pop_ready && !flush;

    gray_ptr_counter #(.W(PW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (wr_inc),
        .bin   (wr_bin),
        .gray  (wr_ptr_gray)
    );

    gray_ptr_counter #(.W(PW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (rd_inc),
        .bin   (rd_bin),
        .gray  (rd_ptr_gray)
    );

    always_comb begin
        count_d = '0;
        if (!flush) begin
            count_d = (wr_bin + PW'(wr_inc)) - (rd_bin + PW'(rd_inc));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign push_entry = '{lit: push_lit, dl: push_dl, is_dec: push_is_dec};

    always_ff @(posedge clk) begin
        if (wr_inc) begin
            mem_q[wr_bin[ADDR_W-1:0]] <= push_entry;
        end
    end

    assign head_entry = mem_q[rd_bin[ADDR_W-1:0]];
    assign pop_lit    = head_entry.lit;
    assign pop_dl     = head_entry.dl;
    assign pop_is_dec = head_entry.is_dec;
    assign count      = count_q;

endmodule
